score_seg_mux: RTL and testbench
================================

# score_seg_mux

Parametrised score keeper and multiplexed seven-segment driver for the game top level. Takes NUM_CH level-type game event lines (enemy destroyed, player hit, bonus, …), detects rising edges, and accumulates them into a saturating BCD score. Time-multiplexes the score onto a DIGITS-wide common-anode display. Replaces the fixed two-event, four-digit score path, and adds simultaneous-event counting, a clear input, a saturation flag and a configurable width.

## Interface
- NUM_CH, 2, number of event inputs; legal 1..9
- DIGITS, 4, BCD digits of score and display; legal 1..8
- REFRESH_DIV, 50000, clk cycles each digit stays lit; must be ≥ 2
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- evt  in  NUM_CH  event levels, synchronous to clk; each rising edge = +1 point
- clr  in  1  synchronous score clear, active-high
- score_bcd  out  4*DIGITS  current score, digit 0 = least-significant nibble
- sat  out  1  sticky: score has hit all-9s
- seg  out  8  segments, active-low; seg[7] = decimal point (always 1 = off)
- an  out  DIGITS  anode enables, active-low, one-hot-low while running

## Operation
- Edge detect: register evt_q <= evt. rise = evt & ~evt_q. inc = popcount(rise), range 0..NUM_CH.
- Score update, priority order each cycle:
  - reset
  - clr: score_bcd = 0, sat = 0; rises in the same cycle are dropped.
  - inc > 0: BCD add of inc to score_bcd with per-digit carry.
  - If the true sum exceeds 10^DIGITS−1: score_bcd = all 9s and sat = 1. There is no wrap.
  - At saturation, further events are ignored and sat stays 1.
- An event held high counts once. It must go low for ≥ 1 cycle before it can count again.
- Refresh counter runs 0..REFRESH_DIV−1. On wrap, digit index idx advances 0..DIGITS−1, then wraps to 0.
- Display outputs:
  - an = ~(1 << idx)
  - seg = active-low 7-seg pattern of nibble idx of score_bcd, with seg[7] = 1.
  - Nibble values 10..15 cannot occur. The decoder maps them to blank (all 1s).
- Reset state: score_bcd = 0, sat = 0, evt_q = 0, counter = 0, idx = 0, seg = 8'hFF, an = all 1s.
- Because evt_q resets to 0, any evt line high on the first cycle after reset counts as a rise.

## Timing
- Score latency: evt rises before clock edge k → score_bcd and sat show the new value after edge k.
- A clr asserted before edge k gives score_bcd = 0 after edge k.
- seg/an are registered from idx and score_bcd, so they lag by 1 cycle.
- The first cycle after reset deasserts: an = {…1110}, seg = "0" pattern (8'hC0).
- Each digit is lit for exactly REFRESH_DIV cycles. The full frame is DIGITS*REFRESH_DIV cycles.
- A score change during a digit's slot appears on seg 1 cycle later, without waiting for the next frame.
- Reset mid-frame: restarts at digit 0 with counter 0 on the following cycle.

## Configuration
- SCORE_LZ_BLANK_EN:
  - Defined: leading-zero blanking. When digit idx > 0 and it and all higher digits are 0, seg = 8'hFF while an still strobes. Digit 0 always shows.
  - Undefined: every digit shows its value, including leading zeros.

## Structure
- Package score_pkg:
  - SEG_BLANK (8'hFF) and the 16-entry active-low segment pattern constant
  - bcd_digit_t (4-bit) typedef
  - popcount function sized by NUM_CH
- Sub-module seven_seg_decode: 4-bit nibble + blank input → 8-bit active-low seg. Purely combinational, registered in the parent.
- BCD saturating add and the refresh/idx counter stay in the parent.

## Test plan
- Single event: reset, then pulse evt[0] high for 3 cycles at score 0 → score_bcd = 16'h0001, counted once, after exactly 1 edge.
- Simultaneous events: NUM_CH=2, score 16'h0099, evt = 2'b11 rising together → 16'h0101, carry across 2 digits in one cycle.
- Saturation: preload to 16'h9998 via events, then 2 simultaneous rises → 16'h9999 and sat = 1. A further rise → unchanged. clr → 16'h0000 and sat = 0.
- clr vs event: clr and evt[1] rise in the same cycle at score 16'h0042 → 16'h0000. Holding evt[1] high afterwards adds nothing.
- Multiplex:
  - Setup: REFRESH_DIV=4, score 16'h1234.
  - an sequence 1110, 1101, 1011, 0111 with 4 cycles each.
  - seg pattern order: 4, 3, 2, 1.
  - Reset mid-frame → an = 1111 for 1 cycle, then 1110.
- Blanking (SCORE_LZ_BLANK_EN defined): score 16'h0007 → digits 1..3 give seg = 8'hFF, digit 0 gives 8'hF8.

Source files
------------

// File: rtl/score_pkg.sv
`default_nettype none
// ============================================================================
// Module      : score_pkg
// Description : Shared constants, the BCD digit type and a popcount helper
//               used by the score keeper and its seven-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package score_pkg;

    localparam int MAX_CH = 9;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][7:0] c_seg_lut = {
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
        8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99,
        8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef logic [3:0] bcd_digit_t;

    function automatic logic [3:0] popcount(input logic [MAX_CH-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_decode.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_decode
// Description : Combinational BCD nibble to active-low segment decoder with a
//               forced-blank input; decimal point is always off.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_decode
    import score_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [7:0] seg
);

    assign seg = blank ? SEG_BLANK : c_seg_lut[nibble];

endmodule
`default_nettype wire

// File: rtl/score_seg_mux.sv
`default_nettype none
// ============================================================================
// Module      : score_seg_mux
// Description : Rising-edge event counter into a saturating BCD score, with a
//               time-multiplexed common-anode seven-segment display driver.
//               Optional leading-zero blanking: define SCORE_LZ_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module score_seg_mux
    import score_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   evt,
    input  logic                clr,
    output logic [4*DIGITS-1:0] score_bcd,
    output logic                sat,
    output logic [7:0]          seg,
    output logic [DIGITS-1:0]   an
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [NUM_CH-1:0]   r_evt_q;
    logic [4*DIGITS-1:0] r_score;
    logic                r_sat;
    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [7:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic [NUM_CH-1:0]   w_rise;
    logic [3:0]          w_inc;
    logic [4*DIGITS-1:0] w_sum;
    logic                w_ovf;
    bcd_digit_t          w_nibble;
    logic                w_blank;
    logic [7:0]          w_seg_dec;

    assign w_rise = evt & ~r_evt_q;
    assign w_inc  = popcount(MAX_CH'(w_rise));

    // Ripple BCD add; digit 0 can absorb up to 9+9, higher digits carry 0/1.
    always_comb begin : p_bcd_add
        logic [4:0] carry;
        logic [4:0] tmp;
        carry = {1'b0, w_inc};
        tmp   = 5'd0;
        w_sum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            tmp = {1'b0, r_score[4*i +: 4]} + carry;
            if (tmp > 5'd9) begin
                w_sum[4*i +: 4] = 4'(tmp - 5'd10);
                carry           = 5'd1;
            end else begin
                w_sum[4*i +: 4] = tmp[3:0];
                carry           = 5'd0;
            end
        end
        w_ovf = (carry != 5'd0);
    end

    assign w_nibble = r_score[r_idx*4 +: 4];

`ifdef SCORE_LZ_BLANK_EN
    logic [DIGITS-1:0] w_upper_zero;

    // w_upper_zero[i]: digit i and every digit above it are zero.
    for (genvar i = 0; i < DIGITS; i++) begin : g_lz
        if (i == DIGITS - 1) begin : g_top
            assign w_upper_zero[i] = (r_score[4*i +: 4] == 4'd0);
        end else begin : g_mid
            assign w_upper_zero[i] = (r_score[4*i +: 4] == 4'd0) && w_upper_zero[i+1];
        end
    end

    assign w_blank = (r_idx != '0) && w_upper_zero[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    seven_seg_decode u_dec (
        .nibble (w_nibble),
        .blank  (w_blank),
        .seg    (w_seg_dec)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_evt_q <= '0;
            r_score <= '0;
            r_sat   <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_seg   <= SEG_BLANK;
            r_an    <= '1;
        end else begin
            r_evt_q <= evt;

            if (clr) begin
                r_score <= '0;
                r_sat   <= 1'b0;
            end else if (!r_sat && (w_inc != 4'd0)) begin
                if (w_ovf) begin
                    r_score <= {DIGITS{4'h9}};
                    r_sat   <= 1'b1;
                end else begin
                    r_score <= w_sum;
                end
            end

            if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_seg <= w_seg_dec;
            r_an  <= ~(DIGITS'(1) << r_idx);
        end
    end

    assign score_bcd = r_score;
    assign sat       = r_sat;
    assign seg       = r_seg;
    assign an        = r_an;

endmodule
`default_nettype wire

// File: tb/tb_score_seg_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_score_seg_mux
// Description : Self-checking bench for score_seg_mux against an integer
//               score / frame-position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_seg_mux;

    localparam int NC = 2;
    localparam int DG = 4;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] evt;
    logic          clr;
    logic [15:0]   score_bcd;
    logic          sat;
    logic [7:0]    seg;
    logic [3:0]    an;

    int n_chk  = 0;
    int n_pass = 0;

    int         m_score;
    bit         m_sat;
    logic [1:0] m_prev;
    int         m_cyc;
    logic [7:0] exp_seg;
    logic [3:0] exp_an;

    always #5 clk = ~clk;

    score_seg_mux #(
        .NUM_CH      (NC),
        .DIGITS      (DG),
        .REFRESH_DIV (RD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .evt       (evt),
        .clr       (clr),
        .score_bcd (score_bcd),
        .sat       (sat),
        .seg       (seg),
        .an        (an)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want)
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
        else
            n_pass++;
    endtask

    function automatic int pow10(input int e);
        int p = 1;
        for (int k = 0; k < e; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        case (d)
            0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
            4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
            8: return 8'h80;  9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] b = '0;
        for (int k = 0; k < DG; k++) b[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return b;
    endfunction

    task automatic step(input logic [1:0] e, input logic c, input logic r);
        int idx;
        int rises;
        evt   = e;
        clr   = c;
        reset = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_score = 0;
            m_sat   = 0;
            m_prev  = 2'b00;
            m_cyc   = 0;
            exp_seg = 8'hFF;
            exp_an  = 4'hF;
        end else begin
            idx     = (m_cyc / RD) % DG;
            m_cyc++;
            exp_an  = ~(4'b0001 << idx);
            exp_seg = seg_of((m_score / pow10(idx)) % 10);
`ifdef SCORE_LZ_BLANK_EN
            if (idx > 0 && m_score < pow10(idx)) exp_seg = 8'hFF;
`endif
            if (c) begin
                m_score = 0;
                m_sat   = 0;
            end else begin
                rises = int'(e[0] & ~m_prev[0]) + int'(e[1] & ~m_prev[1]);
                if (!m_sat && rises > 0) begin
                    if (m_score + rises > pow10(DG) - 1) begin
                        m_score = pow10(DG) - 1;
                        m_sat   = 1;
                    end else begin
                        m_score = m_score + rises;
                    end
                end
            end
            m_prev = e;
        end
        chk("score", 32'(score_bcd), 32'(to_bcd(m_score)));
        chk("sat",   32'(sat),       32'(m_sat));
        chk("seg",   32'(seg),       32'(exp_seg));
        chk("an",    32'(an),        32'(exp_an));
    endtask

    task automatic run_to(input int target);
        while (m_score < target) begin
            if (target - m_score >= 2) step(2'b11, 1'b0, 1'b0);
            else                       step(2'b01, 1'b0, 1'b0);
            step(2'b00, 1'b0, 1'b0);
        end
    endtask

    initial begin
        m_score = 0; m_sat = 0; m_prev = 2'b00; m_cyc = 0;
        exp_seg = 8'hFF; exp_an = 4'hF;
        reset = 1'b1; evt = '0; clr = 1'b0;

        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        chk("rst_score", 32'(score_bcd), 32'h0);
        chk("rst_seg",   32'(seg),       32'hFF);
        chk("rst_an",    32'(an),        32'hF);
        step(2'b00, 1'b0, 1'b0);
        chk("first_an",  32'(an),  32'hE);
        chk("first_seg", 32'(seg), 32'hC0);

        // Single held event counts once, one edge after the rise.
        step(2'b01, 1'b0, 1'b0);
        chk("single_lat", 32'(score_bcd), 32'h0001);
        step(2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk("single", 32'(score_bcd), 32'h0001);

        // Simultaneous rises carrying across two digits.
        run_to(99);
        step(2'b11, 1'b0, 1'b0);
        chk("simul", 32'(score_bcd), 32'h0101);
        step(2'b00, 1'b0, 1'b0);

        // clr beats a same-cycle rise; holding the line adds nothing.
        step(2'b00, 1'b1, 1'b0);
        run_to(42);
        step(2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(2'b10, 1'b0, 1'b0);
        chk("clr_evt", 32'(score_bcd), 32'h0000);
        step(2'b00, 1'b0, 1'b0);

        // Multiplex a static 1234 over two frames, then reset mid-frame.
        run_to(1234);
        for (int i = 0; i < 2 * DG * RD; i++) step(2'b00, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b1);
        chk("mid_rst_an", 32'(an), 32'hF);
        step(2'b00, 1'b0, 1'b0);
        chk("post_rst_an", 32'(an), 32'hE);

        // Saturation and sticky flag, then clear.
        run_to(9998);
        step(2'b11, 1'b0, 1'b0);
        chk("sat_val",  32'(score_bcd), 32'h9999);
        chk("sat_flag", 32'(sat),       32'h1);
        step(2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        chk("sat_hold", 32'(score_bcd), 32'h9999);
        step(2'b00, 1'b1, 1'b0);
        chk("sat_clr",  32'(score_bcd), 32'h0000);
        chk("sat_clr_f", 32'(sat),      32'h0);

        // Leading-zero behaviour over a full frame at score 7.
        run_to(7);
        for (int i = 0; i < DG * RD + 2; i++) step(2'b00, 1'b0, 1'b0);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            step(2'($urandom), ($urandom % 32) == 0, ($urandom % 128) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
